// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Responder side of the MEM-stage data-memory interface. A word-addressed
// storage array services one read or write at a time, each taking a fixed
// LATENCY cycles during which stall_o freezes the upstream pipeline. The
// access commits on the edge that enters DONE; DONE lasts one cycle, pulses
// done_o, and always returns to IDLE so the next request can start at once.
//
// Parameters:
//   DEPTH    number of 32-bit words (power of two, >= 2)
//   LATENCY  cycles stall_o is held per access (>= 1)
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous, active-low reset
//   MemRead_i   read request, held stable while stall_o = 1
//   MemWrite_i  write request, held stable while stall_o = 1
//   addr_i      byte address; word index = addr_i[log2(DEPTH)+1:2]
//   data_i      write data
//   data_o      registered read data, changes only at a read commit
//   stall_o     pipeline freeze request (combinational in IDLE)
//   done_o      one-cycle pulse in the completion cycle
//   err_o       access error, meaningful only while done_o = 1
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;

    // Last BUSY count before commit, and the count loaded on leaving IDLE.
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [31:0]   data_q,  data_d;
    logic          done_q,  done_d;
    logic          err_q,   err_d;

    logic [31:0]   mem [DEPTH];

    logic          req;
    logic          misaligned;
    logic          out_of_range;
    logic          addr_ok;
    logic          access_err;
    logic          commit;
    logic          mem_we;
    logic [AW-1:0] word_idx;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    assign req          = MemRead_i | MemWrite_i;
    assign word_idx     = addr_i[AW+1:2];
    assign misaligned   = (addr_i[1:0] != 2'b00);
    // Any set bit above the indexed range puts the address at or beyond DEPTH*4.
    assign out_of_range = (addr_i[31:AW+2] != '0);
    assign addr_ok      = !misaligned && !out_of_range;
    assign access_err   = !addr_ok || (MemRead_i && MemWrite_i);

    // -------------------------------------------------------------------------
    // Next-state, counter and commit logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred; blocking '=' is correct in
    // combinational logic, while the state registers below use '<='.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        commit  = 1'b0;
        stall_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Combinational so the CPU freezes in the request's first cycle.
                stall_o = req;
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_ONE;
                    end
                end
            end

            ST_BUSY: begin
                stall_o = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
                // The CPU still presents the finished request here; ignore it.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (commit) begin
            done_d = 1'b1;
            err_d  = access_err;
            // Both strobes high is serviced as a write, so data_o is untouched.
            if (MemRead_i && !MemWrite_i) begin
                data_d = addr_ok ? mem[word_idx] : 32'h0;
            end
        end

        // Reset forces the freeze request low regardless of state.
        if (!rst_i) begin
            stall_o = 1'b0;
        end
    end

    // A bad address never touches the array; a reset edge drops the write.
    assign mem_we = commit && MemWrite_i && addr_ok && rst_i;

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= 32'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset on purpose; contents survive rst_i and a
    // resettable array would prevent mapping onto RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[word_idx] <= data_i;
        end
    end

    assign data_o = data_q;
    assign done_o = done_q;
    assign err_o  = err_q;

    // -------------------------------------------------------------------------
    // Structural properties
    // -------------------------------------------------------------------------
    // The counter stays within the BUSY range and never wraps.
    assert property (@(posedge clk_i) disable iff (!rst_i) cnt_q <= CNT_LAST);
    // done_o is a single-cycle pulse.
    assert property (@(posedge clk_i) disable iff (!rst_i) done_q |=> !done_q);

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the pipelined CPU's MEM stage: the responder side of the MemRead/MemWrite/addr/data interface the EX/MEM register drives. It holds a word-addressed storage array and services each access after a fixed, parameterised latency. While an access is in flight it raises `stall_o`, and the CPU freezes PC, IF/ID, ID/EX and EX/MEM on that signal. Its data output feeds the MEM/WB register.

## Interface

Parameters:
- `DEPTH`, 32: number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 4: cycles `stall_o` is held per access; ≥ 1.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `MemRead_i`  in  1  read request; held stable by the CPU while `stall_o`=1.
- `MemWrite_i`  in  1  write request; held stable while `stall_o`=1.
- `addr_i`  in  32  byte address; word index = `addr_i[log2(DEPTH)+1:2]`.
- `data_i`  in  32  write data.
- `data_o`  out  32  registered read data; holds its value between reads.
- `stall_o`  out  1  pipeline freeze request.
- `done_o`  out  1  one-cycle pulse marking the completion cycle.
- `err_o`  out  1  error flag, valid only while `done_o`=1.

## Operation

The block is a three-state FSM: IDLE, BUSY and DONE. A 2-bit state register and a cycle counter `cnt` (width ≥ clog2(LATENCY)+1) drive it.

- **req** = `MemRead_i` | `MemWrite_i`.
- **IDLE**
  - `stall_o` = req, combinational, so the CPU freezes in the same cycle the request appears.
  - On req with LATENCY=1: go to DONE.
  - On req with LATENCY>1: go to BUSY, cnt←1.
- **BUSY**
  - `stall_o`=1.
  - If cnt==LATENCY-1: go to DONE; otherwise cnt←cnt+1.
- **Commit edge** (the edge entering DONE):
  - A write stores `data_i` into `mem[index]`.
  - A read loads `mem[index]` into `data_o`.
  - `err`/`done` are registered at this edge.
- **DONE**
  - `stall_o`=0, `done_o`=1.
  - req is ignored, because the CPU inputs still show the completed request.
  - Next state is always IDLE; the pipeline advances on the same edge.
- **Error** (`err_o`=1 in DONE) when any of these hold:
  - `addr_i[1:0]` ≠ 0;
  - `addr_i` ≥ DEPTH·4;
  - `MemRead_i` and `MemWrite_i` are both high.
- **Error handling:**
  - Misaligned or out-of-range write: the array is not modified.
  - Misaligned or out-of-range read: `data_o`←0.
  - Both high, address valid: treated as a write, and `data_o` is unchanged.
- **Read-only update:** `data_o` changes only at a read commit.

## Timing

- **Reset** (`rst_i`=0 at an edge):
  - state←IDLE, cnt←0, `data_o`←0, `done_o`←0, `err_o`←0.
  - `stall_o` is forced 0 while `rst_i`=0.
  - Array contents are not cleared.
- **Reset mid-access:** the access is abandoned and a pending write is dropped. After reset releases, a still-asserted req starts a fresh access from cycle 0.
- **Access timeline:** request first visible in cycle 0.
  - `stall_o`=1 for cycles 0..LATENCY-1.
  - Commit at the end of cycle LATENCY-1.
  - `done_o`=1 and `data_o` valid in cycle LATENCY.
  - Occupancy is LATENCY+1 cycles per access.
- **Back-to-back accesses:** a request present in the cycle after DONE starts a new access from IDLE; there is no idle bubble beyond DONE.
- **Read-after-write:** a read of the same word in the next access returns the new value.
- **Non-memory instructions:** req=0 in IDLE keeps `stall_o`=0 with no state change.
- **Counter:** never exceeds LATENCY-1 and never wraps.

## Test plan

- **Write then read, LATENCY=4:** write 0xDEADBEEF @0x10, then read @0x10.
  - Expected: `stall_o` high exactly 4 cycles per access.
  - Expected: `done_o` in cycle 4 of the read with `data_o`=0xDEADBEEF and `err_o`=0.
- **LATENCY=1:** read @0x0 after writing 0x12345678.
  - Expected: `stall_o` 1 cycle, `done_o` the next cycle, `data_o`=0x12345678.
- **Misaligned and out-of-range:**
  - Write 0xFFFFFFFF @0x11: `err_o`=1 in DONE; a read @0x10 still returns the prior value.
  - Read @0x80 with DEPTH=32: `err_o`=1, `data_o`=0.
- **Both MemRead and MemWrite high:** write 0xA5A5A5A5 @0x8.
  - Expected: `err_o`=1 and the word is written; a subsequent read returns 0xA5A5A5A5.
- **Reset mid-access:** assert `rst_i`=0 in BUSY cycle 2 of a write of 0x55 @0x4.
  - Expected: outputs 0 during reset, and a later read @0x4 returns the old value.
- **Back-to-back:** three consecutive reads with req held across DONE.
  - Expected: the `done_o` pulses are spaced exactly LATENCY+1 cycles apart.
  - Expected: `stall_o` is low only in the DONE cycles.
